i2c_master_burst_ctrl: RTL

//  Parametrised byte/burst controller between the register front-end and the I2C bit controller.
//  One command runs an optional START, then 1..2^LEN_W words, then an optional STOP, without CPU

---
 rtl/i2c_master_burst_ctrl.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_burst_ctrl.sv
// Byte/burst sequencer sitting between the register front-end and the I2C
// bit controller. One command = optional START, 1..2^LEN_W words, optional
// STOP, with write data streamed in over valid/ready and read data out as a pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no command; waiting for go
// S_START | START (or repeated START) issued, waiting for bit_ack
// S_LOAD  | write burst: waiting for tx_valid, bus parked (NOP)
// S_WBIT  | shifting out DW data bits, MSB first
// S_WACK  | reading the slave ACK bit after a written word
// S_RBIT  | shifting in DW data bits, MSB first
// S_RACK  | sending the master ACK/NACK bit after a read word
// S_STOP  | STOP issued, waiting for bit_ack
// S_DONE  | one-cycle end-of-command pulse; accepts a new go like S_IDLE
module i2c_master_burst_ctrl #(
   parameter int unsigned DW            = 8,
   parameter int unsigned LEN_W         = 4,
   parameter bit          ABORT_ON_NACK = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic             start,
   input  logic             stop,
   input  logic             read,
   input  logic             write,
   input  logic [LEN_W-1:0] len,
   input  logic             tx_ack,
   input  logic [DW-1:0]    tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [DW-1:0]    rx_data,
   output logic             rx_valid,
   output logic             rx_ack,
   output logic             busy,
   output logic [LEN_W-1:0] byte_cnt,
   output logic             i2c_done,
   output logic             nack_err,
   output logic             al_err,
   input  logic             i2c_al,
   output logic [3:0]       bit_cmd,
   output logic             bit_txd,
   input  logic             bit_ack,
   input  logic             bit_rxd
);

   localparam logic [3:0] CMD_NOP   = 4'b0000;
   localparam logic [3:0] CMD_START = 4'b0001;
   localparam logic [3:0] CMD_STOP  = 4'b0010;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_READ  = 4'b1000;

   localparam int unsigned CW = $clog2(DW);
   localparam logic [CW-1:0] BIT_TOP = CW'(DW - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_LOAD, S_WBIT, S_WACK, S_RBIT, S_RACK, S_STOP, S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [3:0]       cmd_nxt;
   logic             txd_nxt;
   logic [DW-1:0]    sreg, sreg_nxt;
   logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
   logic [LEN_W-1:0] byte_cnt_nxt, len_q, len_nxt;
   logic             rd_q, rd_nxt, wr_q, wr_nxt, stop_q, stop_nxt, txack_q, txack_nxt;
   logic             busy_nxt, rx_valid_nxt, rx_ack_nxt, done_nxt, nack_nxt, al_nxt;
   logic [DW-1:0]    rx_data_nxt;
   logic             sel_rd, sel_wr, sel_stop;
   logic             dispatch, finish, end_cmd;
   logic             last_word;

   assign last_word = (byte_cnt == len_q);

   // Next-state and next-output decode; every output except tx_ready is registered.
   always_comb begin
      state_nxt    = state;
      cmd_nxt      = bit_cmd;
      txd_nxt      = bit_txd;
      sreg_nxt     = sreg;
      bit_cnt_nxt  = bit_cnt;
      byte_cnt_nxt = byte_cnt;
      len_nxt      = len_q;
      rd_nxt       = rd_q;
      wr_nxt       = wr_q;
      stop_nxt     = stop_q;
      txack_nxt    = txack_q;
      busy_nxt     = busy;
      rx_data_nxt  = rx_data;
      rx_valid_nxt = 1'b0;
      rx_ack_nxt   = rx_ack;
      done_nxt     = 1'b0;
      nack_nxt     = nack_err;
      al_nxt       = al_err;
      tx_ready     = 1'b0;
      sel_rd       = rd_q;
      sel_wr       = wr_q;
      sel_stop     = stop_q;
      dispatch     = 1'b0;
      finish       = 1'b0;
      end_cmd      = 1'b0;

      case (state)
         S_IDLE, S_DONE: begin
            if (state == S_DONE) state_nxt = S_IDLE;
            if (go) begin
               busy_nxt     = 1'b1;
               byte_cnt_nxt = '0;
               nack_nxt     = 1'b0;
               al_nxt       = 1'b0;
               len_nxt      = len;
               rd_nxt       = read;
               wr_nxt       = write;
               stop_nxt     = stop;
               txack_nxt    = tx_ack;
               sel_rd       = read;
               sel_wr       = write;
               sel_stop     = stop;
               if (start) begin
                  state_nxt = S_START;
                  cmd_nxt   = CMD_START;
                  txd_nxt   = 1'b1;
               end else begin
                  dispatch = 1'b1;
               end
            end
         end
         S_START: if (bit_ack) dispatch = 1'b1;
         S_LOAD: begin
            if (tx_valid) begin
               tx_ready    = 1'b1;
               sreg_nxt    = tx_data;
               bit_cnt_nxt = BIT_TOP;
               state_nxt   = S_WBIT;
               cmd_nxt     = CMD_WRITE;
               txd_nxt     = tx_data[DW-1];
            end
         end
         S_WBIT: begin
            if (bit_ack) begin
               sreg_nxt = {sreg[DW-2:0], 1'b0};
               if (bit_cnt == '0) begin
                  state_nxt = S_WACK;
                  cmd_nxt   = CMD_READ;
                  txd_nxt   = 1'b1;
               end else begin
                  bit_cnt_nxt = bit_cnt - 1'b1;
                  txd_nxt     = sreg[DW-2];
               end
            end
         end
         S_WACK: begin
            if (bit_ack) begin
               rx_ack_nxt   = bit_rxd;
               byte_cnt_nxt = byte_cnt + 1'b1;
               if (bit_rxd && ABORT_ON_NACK) begin
                  nack_nxt = 1'b1;
                  finish   = 1'b1;
               end else if (last_word) begin
                  finish = 1'b1;
               end else begin
                  state_nxt = S_LOAD;
                  cmd_nxt   = CMD_NOP;
               end
            end
         end
         S_RBIT: begin
            if (bit_ack) begin
               sreg_nxt = {sreg[DW-2:0], bit_rxd};
               if (bit_cnt == '0) begin
                  rx_data_nxt  = {sreg[DW-2:0], bit_rxd};
                  rx_valid_nxt = 1'b1;
                  state_nxt    = S_RACK;
                  cmd_nxt      = CMD_WRITE;
                  txd_nxt      = last_word ? txack_q : 1'b0;
               end else begin
                  bit_cnt_nxt = bit_cnt - 1'b1;
               end
            end
         end
         S_RACK: begin
            if (bit_ack) begin
               byte_cnt_nxt = byte_cnt + 1'b1;
               if (last_word) begin
                  finish = 1'b1;
               end else begin
                  state_nxt   = S_RBIT;
                  cmd_nxt     = CMD_READ;
                  txd_nxt     = 1'b1;
                  bit_cnt_nxt = BIT_TOP;
               end
            end
         end
         S_STOP: if (bit_ack) end_cmd = 1'b1;
         default: state_nxt = S_IDLE;
      endcase

      // Read wins over write; a command with neither goes straight to STOP/DONE.
      if (dispatch) begin
         if (sel_rd) begin
            state_nxt   = S_RBIT;
            cmd_nxt     = CMD_READ;
            txd_nxt     = 1'b1;
            bit_cnt_nxt = BIT_TOP;
         end else if (sel_wr) begin
            state_nxt = S_LOAD;
            cmd_nxt   = CMD_NOP;
            txd_nxt   = 1'b1;
         end else begin
            finish = 1'b1;
         end
      end

      if (finish) begin
         if (sel_stop) begin
            state_nxt = S_STOP;
            cmd_nxt   = CMD_STOP;
            txd_nxt   = 1'b1;
         end else begin
            end_cmd = 1'b1;
         end
      end

      if (end_cmd) begin
         state_nxt = S_DONE;
         cmd_nxt   = CMD_NOP;
         txd_nxt   = 1'b1;
         busy_nxt  = 1'b0;
         done_nxt  = 1'b1;
      end

      // Lost arbitration overrides everything, including a coincident bit_ack:
      // the partial word is dropped and the bus is released without STOP.
      if (i2c_al && state != S_IDLE) begin
         state_nxt    = S_DONE;
         cmd_nxt      = CMD_NOP;
         txd_nxt      = 1'b1;
         busy_nxt     = 1'b0;
         done_nxt     = 1'b1;
         al_nxt       = 1'b1;
         tx_ready     = 1'b0;
         rx_valid_nxt = 1'b0;
         rx_data_nxt  = rx_data;
         rx_ack_nxt   = rx_ack;
         byte_cnt_nxt = byte_cnt;
         nack_nxt     = nack_err;
         sreg_nxt     = sreg;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         bit_cmd  <= CMD_NOP;
         bit_txd  <= 1'b1;
         sreg     <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         len_q    <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         stop_q   <= 1'b0;
         txack_q  <= 1'b0;
         busy     <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         rx_ack   <= 1'b0;
         i2c_done <= 1'b0;
         nack_err <= 1'b0;
         al_err   <= 1'b0;
      end else begin
         state    <= state_nxt;
         bit_cmd  <= cmd_nxt;
         bit_txd  <= txd_nxt;
         sreg     <= sreg_nxt;
         bit_cnt  <= bit_cnt_nxt;
         byte_cnt <= byte_cnt_nxt;
         len_q    <= len_nxt;
         rd_q     <= rd_nxt;
         wr_q     <= wr_nxt;
         stop_q   <= stop_nxt;
         txack_q  <= txack_nxt;
         busy     <= busy_nxt;
         rx_data  <= rx_data_nxt;
         rx_valid <= rx_valid_nxt;
         rx_ack   <= rx_ack_nxt;
         i2c_done <= done_nxt;
         nack_err <= nack_nxt;
         al_err   <= al_nxt;
      end
   end

endmodule
